regfile_writeback_queue: RTL

//  Writer-side front end for the 32x64 register file: accepts results from ALU and load

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_fwd_match.sv | 32 +++
 rtl/regfile_writeback_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and queue entry type for the writeback queue
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-match lookup over the queued writeback entries
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]      head_i,
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     data_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match standing is the youngest one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (valid_i[idx] && (entries_i[idx].rd == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order load/ALU result queue feeding the register file write port
module regfile_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [REG_ADDR_W-1:0]       ld_rd,
  input  logic [DATA_W-1:0]           ld_data,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [REG_ADDR_W-1:0]       alu_rd,
  input  logic [DATA_W-1:0]           alu_data,
  output logic                        write_enable,
  output logic [REG_ADDR_W-1:0]       writeAddress,
  output logic [DATA_W-1:0]           dataInput,
  input  logic [REG_ADDR_W-1:0]       fwd_addr,
  output logic                        fwd_hit,
  output logic [DATA_W-1:0]           fwd_data,
  output logic [NUM_REGS-1:0]         busy_mask,
  output logic [$clog2(DEPTH):0]      q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CNT_W-1:0]      count_q, count_d, free;
  logic                  rdy_en_q;
  logic                  ld_acc, alu_acc, pop;

  // Readies are held low through reset and the first cycle after release.
  assign free      = CNT_W'(DEPTH) - count_q;
  assign ld_ready  = rdy_en_q && (free != '0);
  assign alu_ready = rdy_en_q && (ld_valid ? (free >= CNT_W'(2)) : (free != '0));
  assign ld_acc    = ld_valid && ld_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign pop       = (count_q != '0);
  assign alu_slot  = tail_q + PTR_W'(ld_acc);

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (ld_acc) begin
      entries_d[tail_q] = '{rd: ld_rd, data: ld_data};
      valid_d[tail_q]   = 1'b1;
    end
    if (alu_acc) begin
      entries_d[alu_slot] = '{rd: alu_rd, data: alu_data};
      valid_d[alu_slot]   = 1'b1;
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(ld_acc) + PTR_W'(alu_acc);
    count_d = count_q + CNT_W'(ld_acc) + CNT_W'(alu_acc) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries_q <= '0;
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign write_enable = pop;
  assign writeAddress = pop ? entries_q[head_q].rd   : '0;
  assign dataInput    = pop ? entries_q[head_q].data : '0;
  assign q_count      = count_q;

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k]) busy_mask[entries_q[k].rd] = 1'b1;
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_match (
    .head_i    (head_q),
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .addr_i    (fwd_addr),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

endmodule
